mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- Multicycle memory responder: the target end of the processor's memory bus.
- Accepts one load/store request at a time over a valid/ready handshake, waits a fixed number of cycles, then returns read data or write completion with an error flag.
- Word-addressed RAM behind a byte-address interface; replaces the zero-latency data memory when wait states are needed.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array; valid byte addresses 0 .. 4*DEPTH_WORDS-1
- LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15
- INIT_FILE, "riscvtest.txt", hex image loaded into the array at elaboration; empty string skips loading

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low; sampled on rising clk
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  address misaligned or out of range

Behaviour:
- Clock and reset
  - One clock. reset is synchronous and active-low.
  - reset low at a rising edge: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request cleared.
  - req_ready is 0 while reset is low.
  - Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE with reset high.
- IDLE
  - On req_valid & req_ready: capture req_we, req_addr, req_wdata.
  - Go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go directly to RESP.
  - Acceptance latency is 1 cycle. Requester inputs are ignored outside the accept cycle.
- WAIT
  - Counter decrements each cycle.
  - On the cycle the counter is 0: perform the access and go to RESP at the next edge.
  - Counter width is 4 bits.
- Access (performed on the RESP-entry edge)
  - Word index = addr[31:2].
  - err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH_WORDS).
  - Store, no err: RAM[index] <= wdata; rsp_rdata <= 0.
  - Load, no err: rsp_rdata <= RAM[index], reflecting all previously completed stores.
  - err=1: no array write; rsp_rdata <= 0; rsp_err <= 1.
  - rsp_valid <= 1.
- RESP
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake edge: rsp_valid <= 0, rsp_err <= 0, go to IDLE.
  - rsp_rdata holds its last value.
  - A new request can be accepted no earlier than the cycle after the handshake. No bypass; at most one outstanding request.
- Total latency: request accept edge to rsp_valid high is LATENCY+1 cycles.
- Boundary conditions
  - Reset low mid-WAIT: request discarded and no array write occurs.
  - Reset low in RESP: the access has already been committed and stays committed.
  - Last valid address (4*DEPTH_WORDS-4): no error.
  - Address 4*DEPTH_WORDS: out of range, error.
  - Upper address bits are not aliased; they contribute to the range check.
  - req_valid held high continuously: one request accepted per IDLE visit.

Optional Feature:
- Macro: MEM_BYTE_STROBE_EN.
- When defined:
  - Adds input req_wstrb [3:0].
  - Stores write only lanes whose strobe bit is 1 (bit i controls bits 8i+7:8i).
  - Misalignment is then checked only when req_wstrb == 4'b1111 or on loads. Partial-word stores ignore addr[1:0].
- When undefined:
  - No port.
  - Every store writes the full word.
  - Misalignment rules are as above.

Test Plan:
- LATENCY=2, store 32'hDEADBEEF to 0x10 with rsp_ready=1 -> rsp_valid rises 3 cycles after accept, rsp_err=0, rsp_rdata=0. Then load 0x10 -> rsp_rdata=32'hDEADBEEF.
- Load 0x12 (misaligned) and load 0x100 (DEPTH_WORDS=64) -> rsp_err=1, rsp_rdata=0, same latency. Store to 0x100 leaves RAM[0..63] unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata/rsp_err stable and req_ready=0 throughout. After rsp_ready=1, req_ready returns the following cycle.
- Store 32'h12345678 to 0x20, drive reset low during the WAIT state, release, then load 0x20 -> old contents returned; req_ready=0 while reset is low.
- LATENCY=0 with back-to-back requests (req_valid always 1, rsp_ready always 1) -> one response every 2 cycles, each rsp_valid pulse exactly 1 cycle.
- With MEM_BYTE_STROBE_EN: word 0x8 = 32'hAABBCCDD, store 32'h00000011 with wstrb=4'b0001 -> load returns 32'hAABBCC11.

Source files
------------

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - multicycle word RAM responder on a byte-address valid/ready bus
// Optional byte-lane store strobes: define MEM_BYTE_STROBE_EN to add req_wstrb.
module mem_bus_responder #(
  parameter int    DEPTH_WORDS = 64,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = "riscvtest.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit         ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;

  logic [3:0]       cnt;
  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic             accept;
  logic             do_access;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_err;
  logic             misalign;
  logic [IDX_W-1:0] acc_idx;
`ifdef MEM_BYTE_STROBE_EN
  logic [3:0]       cap_wstrb;
  logic [3:0]       acc_wstrb;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign do_access = (state == IDLE && accept && ZERO_LAT) || (state == WAIT && cnt == 4'd0);

  // With zero latency the access happens on the accept edge, so it must use the live request.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
`ifdef MEM_BYTE_STROBE_EN
    acc_wstrb = cap_wstrb;
`endif
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
`ifdef MEM_BYTE_STROBE_EN
      acc_wstrb = req_wstrb;
`endif
    end
  end

`ifdef MEM_BYTE_STROBE_EN
  assign misalign = (acc_addr[1:0] != 2'b00) && (!acc_we || acc_wstrb == 4'hF);
`else
  assign misalign = (acc_addr[1:0] != 2'b00);
`endif
  assign acc_err = misalign || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_idx = acc_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ZERO_LAT ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
`ifdef MEM_BYTE_STROBE_EN
      cap_wstrb <= 4'd0;
`endif
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_we    <= req_we;
          cap_addr  <= req_addr;
          cap_wdata <= req_wdata;
`ifdef MEM_BYTE_STROBE_EN
          cap_wstrb <= req_wstrb;
`endif
          cnt       <= CNT_INIT;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Array is never reset; the write is gated so a reset edge cannot commit a pending store.
  always_ff @(posedge clk) begin
    if (reset && do_access && acc_we && !acc_err) begin
`ifdef MEM_BYTE_STROBE_EN
      for (int i = 0; i < 4; i++)
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
`else
      mem[acc_idx] <= acc_wdata;
`endif
    end
  end
endmodule
